// File: rtl/player_shot_ctrl_pkg.sv
// Shared constants and state type for the player shot sequencer.
package player_shot_ctrl_pkg;

  localparam int unsigned POS_W = 10;
  localparam int unsigned CD_W  = 8;

  localparam int unsigned SHOT_STEP_DEF       = 4;
  localparam int unsigned SHOT_X_OFFSET_DEF   = 6;
  localparam int unsigned SHOT_HEIGHT_DEF     = 8;
  localparam int unsigned SHOT_TOP_DEF        = 16;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 8;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FLY      = 2'd1,
    ST_COOLDOWN = 2'd2
  } shot_state_e;

endpackage

// File: rtl/player_shot_ctrl_frame_timer.sv
// Loadable down-counter stepped by the frame strobe; done while the count is zero.
module frame_timer
  import player_shot_ctrl_pkg::*;
#(
  parameter int unsigned W = CD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_frame,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_frame && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/player_shot_ctrl.sv
// Player missile sequencer: fire arbitration, launch, per-frame climb, retire and reload delay.
module player_shot_ctrl
  import player_shot_ctrl_pkg::*;
#(
  parameter int unsigned SHOT_STEP       = SHOT_STEP_DEF,
  parameter int unsigned SHOT_X_OFFSET   = SHOT_X_OFFSET_DEF,
  parameter int unsigned SHOT_HEIGHT     = SHOT_HEIGHT_DEF,
  parameter int unsigned SHOT_TOP        = SHOT_TOP_DEF,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             game_active,
  input  logic             fire,
  input  logic [POS_W-1:0] player_x,
  input  logic [POS_W-1:0] player_y,
  input  logic             hit,
  output logic [POS_W-1:0] shot_x,
  output logic [POS_W-1:0] shot_y,
  output logic             shot_active,
  output logic             shot_fired,
  output logic             ready
);

  localparam logic [POS_W-1:0] LAUNCH_MIN = POS_W'(SHOT_TOP + SHOT_HEIGHT);
  localparam logic [POS_W-1:0] RETIRE_LIM = POS_W'(SHOT_TOP + SHOT_STEP);
  localparam logic [POS_W-1:0] STEP_V     = POS_W'(SHOT_STEP);
  localparam logic [POS_W-1:0] XOFF_V     = POS_W'(SHOT_X_OFFSET);
  localparam logic [POS_W-1:0] HEIGHT_V   = POS_W'(SHOT_HEIGHT);
  localparam logic [CD_W-1:0]  CD_V       = CD_W'(COOLDOWN_FRAMES);

  shot_state_e      r_state, w_state_nxt;
  logic             r_fire_q, r_pending, w_pending_nxt;
  logic [POS_W-1:0] r_shot_x, r_shot_y, w_shot_x_nxt, w_shot_y_nxt;
  logic             r_active, w_active_nxt, r_fired, w_fired_nxt, r_ready;
  logic             w_fire_rise, w_tmr_load, w_tmr_done;
  logic [CD_W-1:0]  w_tmr_val;

  assign w_fire_rise = fire & ~r_fire_q;

  frame_timer #(.W(CD_W)) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_frame    (frame),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_READY;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_shot_x_nxt  = r_shot_x;
    w_shot_y_nxt  = r_shot_y;
    w_active_nxt  = r_active;
    w_fired_nxt   = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = CD_V;
    if (!game_active) begin
      w_state_nxt   = ST_READY;
      w_pending_nxt = 1'b0;
      w_active_nxt  = 1'b0;
      w_tmr_load    = 1'b0;
    end else begin
      unique case (r_state)
        ST_READY: begin
          // A pending request is consumed by the frame even when the launch is refused.
          if (frame && r_pending) begin
            w_pending_nxt = 1'b0;
            if (player_y >= LAUNCH_MIN) begin
              w_shot_x_nxt = player_x + XOFF_V;
              w_shot_y_nxt = player_y - HEIGHT_V;
              w_active_nxt = 1'b1;
              w_fired_nxt  = 1'b1;
              w_state_nxt  = ST_FLY;
            end
          end else if (w_fire_rise) begin
            w_pending_nxt = 1'b1;
          end
        end
        ST_FLY: begin
          // Hit outranks the frame step; the top check precedes the subtract.
          if (hit || (frame && (r_shot_y < RETIRE_LIM))) begin
            w_active_nxt = 1'b0;
            w_tmr_load   = 1'b1;
            w_state_nxt  = ST_COOLDOWN;
          end else if (frame) begin
            w_shot_y_nxt = r_shot_y - STEP_V;
          end
        end
        ST_COOLDOWN: begin
          if (w_tmr_done) w_state_nxt = ST_READY;
        end
        default: w_state_nxt = ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fire_q  <= 1'b1;
      r_pending <= 1'b0;
      r_shot_x  <= '0;
      r_shot_y  <= '0;
      r_active  <= 1'b0;
      r_fired   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_fire_q  <= fire;
      r_pending <= w_pending_nxt;
      r_shot_x  <= w_shot_x_nxt;
      r_shot_y  <= w_shot_y_nxt;
      r_active  <= w_active_nxt;
      r_fired   <= w_fired_nxt;
      r_ready   <= (w_state_nxt == ST_READY);
    end
  end

  assign shot_x      = r_shot_x;
  assign shot_y      = r_shot_y;
  assign shot_active = r_active;
  assign shot_fired  = r_fired;
  assign ready       = r_ready;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed bench for player_shot_ctrl: default build plus a zero-cooldown build on shared stimulus.
module tb_player_shot_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame = 1'b0;
  logic       game_active = 1'b1;
  logic       fire = 1'b1;
  logic [9:0] player_x = '0;
  logic [9:0] player_y = '0;
  logic       hit = 1'b0;

  logic [9:0] a_x, a_y, z_x, z_y;
  logic       a_act, a_fired, a_rdy, z_act, z_fired, z_rdy;

  int n_cmp = 0;
  int n_err = 0;
  int n_fired_a = 0;
  int n_fired_z = 0;
  int exp_y;

  always #5 clk = ~clk;

  player_shot_ctrl dut (
    .clk(clk), .rst(rst), .frame(frame), .game_active(game_active), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .shot_x(a_x), .shot_y(a_y), .shot_active(a_act), .shot_fired(a_fired), .ready(a_rdy)
  );

  player_shot_ctrl #(.COOLDOWN_FRAMES(0)) dut_z (
    .clk(clk), .rst(rst), .frame(frame), .game_active(game_active), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .shot_x(z_x), .shot_y(z_y), .shot_active(z_act), .shot_fired(z_fired), .ready(z_rdy)
  );

  always @(negedge clk) begin
    if (a_fired) n_fired_a++;
    if (z_fired) n_fired_z++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    tick();
  endtask

  task automatic press_fire();
    fire = 1'b0;
    tick();
    fire = 1'b1;
    tick();
  endtask

  initial begin
    // Reset with fire held: no launch afterwards
    rst = 1'b0; fire = 1'b1; player_x = 10'd100; player_y = 10'd300;
    tick(); tick();
    rst = 1'b1;
    check_eq("rst_active", int'(a_act), 0);
    check_eq("rst_ready", int'(a_rdy), 1);
    check_eq("rst_x", int'(a_x), 0);
    check_eq("rst_y", int'(a_y), 0);
    check_eq("rst_fired", int'(a_fired), 0);
    for (int i = 0; i < 3; i++) do_frame();
    check_eq("held_fire_no_launch", int'(a_act), 0);
    check_eq("held_fire_no_pulse", n_fired_a, 0);

    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("launch_active", int'(a_act), 1);
    check_eq("launch_pulse", int'(a_fired), 1);
    check_eq("launch_x", int'(a_x), 106);
    check_eq("launch_y", int'(a_y), 292);
    check_eq("launch_ready", int'(a_rdy), 0);
    tick();
    check_eq("pulse_one_cycle", int'(a_fired), 0);
    tick();
    check_eq("pulse_count", n_fired_a, 1);

    // Abort mid-flight
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    check_eq("abort_fly_active", int'(a_act), 0);
    check_eq("abort_fly_ready", int'(a_rdy), 1);
    check_eq("abort_fly_y_hold", int'(a_y), 292);

    // Full climb from 440 with x wrap, fire toggling during flight
    player_x = 10'd1020; player_y = 10'd440;
    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("climb_launch_y", int'(a_y), 432);
    check_eq("climb_launch_x_wrap", int'(a_x), 2);
    exp_y = 432;
    for (int k = 1; k <= 104; k++) begin
      fire = k[0];
      do_frame();
      exp_y -= 4;
      check_eq("climb_y", int'(a_y), exp_y);
      check_eq("climb_active", int'(a_act), 1);
    end
    fire = 1'b1;
    do_frame();
    check_eq("top_retire_active", int'(a_act), 0);
    check_eq("top_retire_y_hold", int'(a_y), 16);
    press_fire();
    for (int k = 1; k <= 7; k++) begin
      do_frame();
      check_eq("cooldown_ready_low", int'(a_rdy), 0);
      check_eq("cooldown_no_launch", int'(a_act), 0);
    end
    do_frame();
    check_eq("cooldown_end_ready", int'(a_rdy), 1);
    do_frame();
    check_eq("no_queued_launch", int'(a_act), 0);
    check_eq("climb_pulse_count", n_fired_a, 2);

    // Hit together with frame at y=200
    player_x = 10'd50; player_y = 10'd208;
    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("hit_launch_y", int'(a_y), 200);
    check_eq("hit_launch_x", int'(a_x), 56);
    frame = 1'b1; hit = 1'b1;
    tick();
    frame = 1'b0; hit = 1'b0;
    check_eq("hit_active", int'(a_act), 0);
    check_eq("hit_no_step_y", int'(a_y), 200);
    hit = 1'b1;
    do_frame();
    hit = 1'b0;
    check_eq("hit_in_cooldown_ready", int'(a_rdy), 0);
    check_eq("hit_in_cooldown_y", int'(a_y), 200);

    // Abort mid-cooldown, then a normal launch
    game_active = 1'b0;
    tick();
    game_active = 1'b1;
    check_eq("abort_cd_ready", int'(a_rdy), 1);
    check_eq("abort_cd_active", int'(a_act), 0);
    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("relaunch_active", int'(a_act), 1);
    check_eq("relaunch_y", int'(a_y), 200);

    // Zero-cooldown build: launch limit and immediate reload
    fire = 1'b0; rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_fired_z = 0;
    player_x = 10'd200; player_y = 10'd20;
    press_fire();
    do_frame();
    check_eq("z_low_drop_active", int'(z_act), 0);
    check_eq("z_low_drop_ready", int'(z_rdy), 1);
    player_y = 10'd100;
    do_frame();
    check_eq("z_pending_cleared", int'(z_act), 0);
    check_eq("z_drop_no_pulse", n_fired_z, 0);
    player_y = 10'd23;
    press_fire();
    do_frame();
    check_eq("z_limit_minus1_drop", int'(z_act), 0);
    player_y = 10'd100;
    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("z_launch_active", int'(z_act), 1);
    check_eq("z_launch_y", int'(z_y), 92);
    check_eq("z_launch_x", int'(z_x), 206);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check_eq("z_hit_active", int'(z_act), 0);
    check_eq("z_hit_ready_low", int'(z_rdy), 0);
    tick();
    check_eq("z_ready_next_cycle", int'(z_rdy), 1);
    player_y = 10'd24;
    press_fire();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("z_limit_launch_active", int'(z_act), 1);
    check_eq("z_limit_launch_y", int'(z_y), 16);
    do_frame();
    check_eq("z_limit_retire", int'(z_act), 0);
    check_eq("z_limit_retire_ready", int'(z_rdy), 1);
    check_eq("z_pulse_count", n_fired_z, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
